// File: rtl/mult_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_pkg : shared widths, pipeline stage record and arbitration helpers  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mult_pkg;

  localparam int MULT_W   = 28;
  localparam int PROD_W   = 56;
  localparam int MAX_NREQ = 8;
  localparam int MAX_IDW  = 3;
  // One row per multiplier bit plus the +1 that completes the negated top row.
  localparam int PP_ROWS  = MULT_W + 1;

  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
    logic               tc;
  } stage_t;

  function automatic logic [MAX_NREQ-1:0] rr_next(input logic [MAX_IDW-1:0]  ptr,
                                                  input logic [MAX_NREQ-1:0] req,
                                                  input int                  nreq);
    logic [MAX_NREQ-1:0] gnt;
    logic                found;
    logic [MAX_IDW-1:0]  idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_NREQ; k++) begin
      if (k <= nreq) begin
        idx = MAX_IDW'((int'(ptr) + k) % nreq);
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

  function automatic int csa_rows(input int lvl);
    int n;
    n = PP_ROWS;
    for (int i = 0; i < lvl; i++) n = (n / 3) * 2 + (n % 3);
    return n;
  endfunction

  function automatic int csa_levels();
    int n;
    int lv;
    n  = PP_ROWS;
    lv = 0;
    while (n > 2) begin
      n  = (n / 3) * 2 + (n % 3);
      lv = lv + 1;
    end
    return lv;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_cs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_cs : 28x28 Wallace-tree multiplier, carry-save (sum/carry) output   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mult_cs
  import mult_pkg::*;
(
  input  logic [MULT_W-1:0] a,
  input  logic [MULT_W-1:0] b,
  input  logic              tc,
  output logic [PROD_W-1:0] sum,
  output logic [PROD_W-1:0] carry
);

  localparam int NLVL = csa_levels();

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] tree [NLVL+1][PP_ROWS];

  always_comb begin
    int                n;
    int                g;
    logic [PROD_W-1:0] x;
    logic [PROD_W-1:0] y;
    logic [PROD_W-1:0] z;
    a_ext = tc ? {{(PROD_W-MULT_W){a[MULT_W-1]}}, a} : {{(PROD_W-MULT_W){1'b0}}, a};
    for (int l = 0; l <= NLVL; l++)
      for (int r = 0; r < PP_ROWS; r++) tree[l][r] = '0;
    for (int i = 0; i < MULT_W; i++)
      if (b[i]) tree[0][i] = a_ext << i;
    // Signed B weights its MSB by -2^27: add the one's complement row plus 1.
    if (tc && b[MULT_W-1]) begin
      tree[0][MULT_W-1] = ~(a_ext << (MULT_W-1));
      tree[0][MULT_W]   = PROD_W'(1);
    end
    for (int l = 1; l <= NLVL; l++) begin
      n = csa_rows(l-1);
      g = n / 3;
      for (int j = 0; j < PP_ROWS / 3; j++) begin
        if (j < g) begin
          x = tree[l-1][3*j];
          y = tree[l-1][3*j+1];
          z = tree[l-1][3*j+2];
          tree[l][2*j]   = x ^ y ^ z;
          tree[l][2*j+1] = ((x & y) | (x & z) | (y & z)) << 1;
        end
      end
      for (int r = 0; r < 2; r++)
        if (r < n % 3) tree[l][2*g+r] = tree[l-1][3*g+r];
    end
    sum   = tree[NLVL][0];
    carry = tree[NLVL][1];
  end

endmodule
`default_nettype wire

// File: rtl/rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arb : round-robin arbiter, pointer moves to the winner on handshake   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_arb
  import mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

  logic [IDW-1:0]      ptr_q;
  logic [IDW-1:0]      ptr_d;
  logic [MAX_NREQ-1:0] gnt_full;
  logic                unused_gnt;

  always_comb begin
    gnt_full = rr_next(MAX_IDW'(ptr_q), MAX_NREQ'(req), NREQ);
    gnt      = en ? gnt_full[NREQ-1:0] : '0;
    ptr_d    = ptr_q;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) ptr_d = IDW'(i);
  end

  assign unused_gnt = ^(gnt_full >> NREQ);

  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= IDW'(NREQ-1);
    else          ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/mult_share_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_share_arb : one shared 28x28 multiplier, RR-arbitrated, 3 stages    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mult_share_arb
  import mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*MULT_W-1:0] req_a,
  input  logic [NREQ*MULT_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_tc,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [PROD_W-1:0]      rsp_product,
  output logic                   busy
);

  logic              adv;
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;
  stage_t            s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [MULT_W-1:0] a_q, a_d, b_q, b_d;
  logic [PROD_W-1:0] sum_q, sum_d, carry_q, carry_d, prod_q, prod_d;
  logic [PROD_W-1:0] mc_sum, mc_carry;
  logic              unused_s3;

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (adv),
    .req     (req_valid),
    .gnt     (gnt)
  );

  mult_cs u_mult (
    .a     (a_q),
    .b     (b_q),
    .tc    (s1_q.tc),
    .sum   (mc_sum),
    .carry (mc_carry)
  );

  // Whole pipe moves in lockstep; an empty slot still occupies its stage.
  always_comb begin
    adv     = !s3_q.valid || rsp_ready;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) gnt_idx = IDW'(i);
    s1_d    = s1_q;
    s2_d    = s2_q;
    s3_d    = s3_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    prod_d  = prod_q;
    if (adv) begin
      s1_d.valid = |gnt;
      s1_d.id    = MAX_IDW'(gnt_idx);
      s1_d.tc    = req_tc[gnt_idx];
      a_d        = req_a[int'(gnt_idx)*MULT_W +: MULT_W];
      b_d        = req_b[int'(gnt_idx)*MULT_W +: MULT_W];
      s2_d       = s1_q;
      sum_d      = mc_sum;
      carry_d    = mc_carry;
      s3_d       = s2_q;
      prod_d     = sum_q + carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      prod_q  <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      prod_q  <= prod_d;
    end
  end

  assign req_ready   = gnt;
  assign rsp_valid   = s3_q.valid;
  assign rsp_id      = s3_q.id[IDW-1:0];
  assign rsp_product = prod_q;
  assign busy        = s1_q.valid || s2_q.valid || s3_q.valid;
  assign unused_s3   = s3_q.tc ^ (^(s3_q.id >> IDW));

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arb.sv
`default_nettype none
// Bench for mult_share_arb: directed table, corner sequences and a random mix,
// all checked each cycle against a transaction-level model of the shared pipe.
module tb_mult_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*28-1:0]   req_a;
  logic [NREQ*28-1:0]   req_b;
  logic [NREQ-1:0]      req_tc;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [55:0]          rsp_product;
  logic                 busy;

  always #5 clk = ~clk;

  mult_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tc      (req_tc),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  typedef struct { bit v; int id; logic [55:0] p; } slot_t;
  typedef struct { int id; logic [27:0] a; logic [27:0] b; bit tc; logic [55:0] exp; } vec_t;

  slot_t pipe [3];
  int    m_ptr;
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    g_hs;
  logic        s_rsp_valid;
  logic [NREQ-1:0] s_req_ready;
  logic [IDW-1:0]  s_rsp_id;
  logic [55:0]     s_rsp_prod;

  function automatic logic [55:0] ref_prod(input logic [27:0] a, input logic [27:0] b, input bit tc);
    longint sa, sb;
    sa = tc ? longint'($signed(a)) : longint'(a);
    sb = tc ? longint'($signed(b)) : longint'(b);
    return 56'(sa * sb);
  endfunction

  function automatic logic [27:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 28'h0000000;
      1:       return 28'hFFFFFFF;
      2:       return 28'h8000000;
      3:       return 28'h7FFFFFF;
      default: return 28'($urandom);
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 56'd0};
    m_ptr = NREQ - 1;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    bit              adv;
    int              gi;
    logic [NREQ-1:0] eg;
    #1;
    adv = !pipe[2].v || rsp_ready;
    gi  = -1;
    if (adv)
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (gi < 0 && req_valid[idx]) gi = idx;
      end
    eg = '0;
    if (gi >= 0) eg[gi] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(eg));
    chk("rsp_valid", 64'(rsp_valid), 64'(pipe[2].v));
    if (pipe[2].v) begin
      chk("rsp_id", 64'(rsp_id), 64'(pipe[2].id));
      chk("rsp_product", 64'(rsp_product), 64'(pipe[2].p));
    end
    chk("busy", 64'(busy), 64'(pipe[0].v || pipe[1].v || pipe[2].v));
    s_rsp_valid = rsp_valid;
    s_req_ready = req_ready;
    s_rsp_id    = rsp_id;
    s_rsp_prod  = rsp_product;
    g_hs        = reset_n && gi >= 0;
    if (!reset_n) model_reset();
    else if (adv) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (gi >= 0) begin
        pipe[0] = '{1, gi, ref_prod(req_a[gi*28 +: 28], req_b[gi*28 +: 28], req_tc[gi])};
        m_ptr   = gi;
      end else begin
        pipe[0] = '{0, 0, 56'd0};
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_operands();
    for (int r = 0; r < NREQ; r++) begin
      req_a[r*28 +: 28] = rand_op();
      req_b[r*28 +: 28] = rand_op();
      req_tc[r]         = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [9];
    logic [5:0]  gseq [6];
    bit          hs, got;
    int          lat, cnt, issued, nrsp;

    tbl[0] = '{0, 28'h0000003, 28'h0000005, 0, 56'h0000000000000F};
    tbl[1] = '{2, 28'hFFFFFFF, 28'h0000002, 1, 56'hFFFFFFFFFFFFFE};
    tbl[2] = '{2, 28'hFFFFFFF, 28'h0000002, 0, 56'h0000001FFFFFFE};
    tbl[3] = '{2, 28'h8000000, 28'h8000000, 1, 56'h40000000000000};
    tbl[4] = '{1, 28'hFFFFFFF, 28'hFFFFFFF, 0, 56'hFFFFFFE0000001};
    tbl[5] = '{3, 28'hFFFFFFF, 28'hFFFFFFF, 1, 56'h00000000000001};
    tbl[6] = '{1, 28'h8000000, 28'h0000001, 1, 56'hFFFFFFF8000000};
    tbl[7] = '{3, 28'h7FFFFFF, 28'h8000000, 1, 56'hC0000008000000};
    tbl[8] = '{0, 28'h0000000, 28'h1234567, 0, 56'h00000000000000};
    gseq[0] = 6'h1; gseq[1] = 6'h2; gseq[2] = 6'h4;
    gseq[3] = 6'h8; gseq[4] = 6'h1; gseq[5] = 6'h2;

    reset_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_tc = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    #1;
    chk("reset_rsp_valid",   64'(rsp_valid),   64'd0);
    chk("reset_rsp_id",      64'(rsp_id),      64'd0);
    chk("reset_rsp_product", 64'(rsp_product), 64'd0);
    chk("reset_busy",        64'(busy),        64'd0);
    chk("reset_req_ready",   64'(req_ready),   64'd0);
    reset_n = 1'b1;

    // Directed single operations: latency, product and one-cycle response.
    for (int e = 0; e < 9; e++) begin
      req_a = '0; req_b = '0; req_tc = '0;
      req_a[tbl[e].id*28 +: 28] = tbl[e].a;
      req_b[tbl[e].id*28 +: 28] = tbl[e].b;
      req_tc[tbl[e].id]         = tbl[e].tc;
      req_valid = NREQ'(1 << tbl[e].id);
      hs = 0;
      for (int c = 0; c < 8 && !hs; c++) begin step(); hs = g_hs; end
      chk("tbl_handshake", 64'(hs), 64'd1);
      req_valid = '0;
      lat = 0; got = 0;
      for (int c = 0; c < 8 && !got; c++) begin
        step();
        lat++;
        if (s_rsp_valid) begin
          got = 1;
          chk("tbl_id", 64'(s_rsp_id), 64'(tbl[e].id));
          chk("tbl_product", 64'(s_rsp_prod), 64'(tbl[e].exp));
        end
      end
      chk("tbl_latency", 64'(lat), 64'd3);
      step();
      chk("tbl_pulse_width", 64'(s_rsp_valid), 64'd0);
    end

    // Everyone requesting from reset: strict rotation starting at 0.
    reset_n = 1'b0; req_valid = '0; step(); reset_n = 1'b1;
    rand_operands();
    req_valid = '1; rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("grant_seq", 64'(s_req_ready), 64'(gseq[k]));
    end

    // Full pipe stalled by the consumer, then released.
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_req_ready", 64'(s_req_ready), 64'd0);
      chk("stall_rsp_valid", 64'(s_rsp_valid), 64'd1);
    end
    rsp_ready = 1'b1; req_valid = '0; cnt = 0;
    for (int k = 0; k < 4; k++) begin step(); if (s_rsp_valid) cnt++; end
    chk("stall_drain_count", 64'(cnt), 64'd3);

    // Reset with three operations in flight.
    req_valid = '1; rand_operands();
    repeat (3) step();
    reset_n = 1'b0; req_valid = '0; step(); reset_n = 1'b1;
    step();
    chk("flush_rsp_valid", 64'(s_rsp_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    req_valid = '1;
    step();
    chk("flush_first_grant", 64'(s_req_ready), 64'd1);
    req_valid = '0;
    repeat (4) step();

    // Random mix against the model.
    issued = 0; nrsp = 0;
    for (int c = 0; c < 3000 && issued < 64; c++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_operands();
      step();
      if (g_hs) issued++;
      if (s_rsp_valid && rsp_ready) nrsp++;
    end
    chk("rand_issued", 64'(issued), 64'd64);
    req_valid = '0; rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin step(); if (s_rsp_valid) nrsp++; end
    chk("rand_response_count", 64'(nrsp), 64'(issued));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
